instr_prefetch_queue: RTL

Instruction fetch front end with a small in-order prefetch buffer. It sits between instruction memory and the IF/ID pipeline register. It issues sequential word fetches over a request/grant/response handshake with variable latency. It presents one instruction per cycle to decode, honours load-use stall (hold) and branch/jump flush (redirect), and discards in-flight responses made stale by a redirect.

---
 rtl/constants.sv | 10 +
 rtl/instr_prefetch_queue_fifo.sv | 69 ++++++
 rtl/instr_prefetch_queue.sv | 123 ++++++++++++
 3 files changed

// File: rtl/constants.sv
// Shared fetch-path constants: word width, NOP encoding and PC step.
`ifndef IFQ_CONSTANTS_SV
`define IFQ_CONSTANTS_SV

`define WORD 32
// RV32I canonical NOP: addi x0, x0, 0
`define NOP 32'h0000_0013
`define PC_INC 32'd4

`endif

// File: rtl/instr_prefetch_queue_fifo.sv
// ifq_fifo: synchronous in-order FIFO with flush, occupancy and head outputs.
`ifndef IFQ_CONSTANTS_SV
`include "constants.sv"
`endif

module ifq_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2 * `WORD
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [WIDTH-1:0]             head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Pointer and occupancy next state; flush empties the queue outright.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while not counted as occupied.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: sequential instruction prefetcher with credit-limited issue,
// in-order buffering, stall hold and flush with stale-response dropping.
// Optional feature macro: IFQ_BYPASS_EN forwards a response straight to decode when
// the buffer is empty.
`ifndef IFQ_CONSTANTS_SV
`include "constants.sv"
`endif

module instr_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [`WORD-1:0]  imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [`WORD-1:0]  imem_rdata,
    input  logic              flush,
    input  logic [`WORD-1:0]  flush_pc,
    input  logic              stall,
    output logic              inst_valid,
    output logic [`WORD-1:0]  inst,
    output logic [`WORD-1:0]  inst_pc
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned EW = 2 * `WORD;

    logic [CW-1:0]    outst_q, outst_d;
    logic [CW-1:0]    drop_q, drop_d;
    logic [`WORD-1:0] fetch_pc_q, fetch_pc_d;
    logic [`WORD-1:0] resp_pc_q, resp_pc_d;

    logic [CW-1:0]    occ;
    logic [EW-1:0]    head;
    logic [CW:0]      credit_used;
    logic             gnt_fire;
    logic             rsp_drop;
    logic             rsp_keep;
    logic             buf_valid;
    logic             byp_hit;
    logic             byp_consume;
    logic             push;
    logic             pop;

    // Issue credit, response classification and buffer control.
    always_comb begin
        credit_used = {1'b0, occ} + {1'b0, outst_q};
        imem_req    = !rst && !flush && (credit_used < (CW + 1)'(DEPTH));
        imem_addr   = fetch_pc_q;
        gnt_fire    = imem_req && imem_gnt;
        rsp_drop    = imem_rvalid && (drop_q != '0);
        rsp_keep    = imem_rvalid && (drop_q == '0) && !flush;
        buf_valid   = occ != '0;
`ifdef IFQ_BYPASS_EN
        byp_hit     = !buf_valid && (drop_q == '0) && imem_rvalid && !flush;
`else
        byp_hit     = 1'b0;
`endif
        byp_consume = byp_hit && !stall;
        push        = rsp_keep && !byp_consume;
        pop         = buf_valid && !stall && !flush;
    end

    // Decode-facing outputs: buffer head first, bypassed response otherwise.
    always_comb begin
        inst_valid = buf_valid || byp_hit;
        inst       = `NOP;
        inst_pc    = '0;
        if (buf_valid) begin
            inst    = head[`WORD-1:0];
            inst_pc = head[EW-1:`WORD];
        end else if (byp_hit) begin
            inst    = imem_rdata;
            inst_pc = resp_pc_q;
        end
    end

    // Counter and PC next state; a flush turns all surviving in-flight requests stale.
    always_comb begin
        outst_d    = outst_q + CW'(gnt_fire) - CW'(imem_rvalid);
        drop_d     = drop_q - CW'(rsp_drop);
        fetch_pc_d = gnt_fire ? fetch_pc_q + `PC_INC : fetch_pc_q;
        resp_pc_d  = rsp_keep ? resp_pc_q + `PC_INC : resp_pc_q;
        if (flush) begin
            drop_d     = outst_d;
            fetch_pc_d = flush_pc;
            resp_pc_d  = flush_pc;
        end
    end

    // Fetch-side state with synchronous reset; memory is reset too so nothing is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            outst_q    <= '0;
            drop_q     <= '0;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
        end else begin
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({resp_pc_q, imem_rdata}),
        .pop       (pop),
        .flush     (flush),
        .count     (occ),
        .head      (head)
    );

endmodule
